swizzle_cram_to_dram_pp: RTL and testbench

Parametrised ping-pong swizzle unit between the compute-RAM (CRAM) read port and the DRAM memory-controller write port. It collects square blocks of `DWIDTH` words of `DWIDTH` bits from the CRAM stream and transposes each block, turning bit-serial CRAM columns into DRAM words. It then writes the transposed words to consecutive memory-controller addresses. Handshakes are full valid/ready on both sides. A block ending early on `in_last` is zero-padded. A pass-through mode skips the transpose.

---
 rtl/swizzle_cram_to_dram_pp.sv | 240 ++++++++++++++++++++++++
 tb/tb_swizzle_cram_to_dram_pp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/swizzle_cram_to_dram_pp.sv
// Ping-pong block transposer from the CRAM read stream to the DRAM write port.
// Two banks alternate between filling and draining; pass-through mode skips the transpose.
module swizzle_cram_to_dram_pp #(
    parameter int DWIDTH = 40,
    parameter int AWIDTH = 9,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [AWIDTH-1:0] addr_start,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_we,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH-1:0] out_addr,
    input  logic              out_ready,
    output logic              done,
    output logic [CWIDTH-1:0] blocks_written
);

    localparam int RW = $clog2(DWIDTH + 1);
    localparam int KW = $clog2(DWIDTH);
    localparam logic [RW-1:0] ROWS     = RW'(DWIDTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(DWIDTH - 1);

    typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_DRAINING = 2'd3} bank_state_t;
    typedef enum logic {D_IDLE = 1'b0, D_DRAIN = 1'b1} drain_state_t;

    logic [DWIDTH-1:0] mem_r [2][DWIDTH];
    bank_state_t       bstate_r [2];
    logic [RW-1:0]     rcnt_r [2];
    logic              mode_r [2];
    logic              last_r [2];
    logic [AWIDTH-1:0] base_r [2];
    logic              fill_ptr_r, drain_ptr_r, new_stream_r;
    logic [AWIDTH-1:0] stream_base_r, offset_r;
    drain_state_t      dstate_r;
    logic [RW-1:0]     k_r;
    logic              out_we_r, done_r;
    logic [DWIDTH-1:0] out_data_r;
    logic [AWIDTH-1:0] out_addr_r;
    logic [CWIDTH-1:0] blocks_r;

    // "_v_s" arrays are the bank contents as they will be after this edge
    logic [DWIDTH-1:0] mem_v_s [2][DWIDTH];
    bank_state_t       bstate_v_s [2];
    logic [RW-1:0]     rcnt_v_s [2];
    logic              mode_v_s [2];
    logic              last_v_s [2];
    logic [AWIDTH-1:0] base_v_s [2];
    logic              fill_ptr_nx_s, drain_ptr_nx_s, new_stream_nx_s;
    logic [AWIDTH-1:0] stream_base_nx_s, offset_nx_s, off_s, start_off_s, out_addr_nx_s;
    drain_state_t      dstate_nx_s;
    logic [RW-1:0]     k_nx_s, drain_len_s;
    logic [KW-1:0]     sel_k_s;
    logic              sel_bank_s, start_s, start_bank_s, load_word_s;
    logic              out_we_nx_s, done_nx_s;
    logic [DWIDTH-1:0] word_s;
    logic [CWIDTH-1:0] blocks_nx_s;
    logic              acc_in_s, out_acc_s;

    assign in_ready  = !reset && (bstate_r[fill_ptr_r] == B_EMPTY || bstate_r[fill_ptr_r] == B_FILLING);
    assign acc_in_s  = in_valid && in_ready;
    assign out_acc_s = out_we_r && out_ready;

    // Next-state for fill side, drain FSM and the next output word
    always_comb begin
        mem_v_s          = mem_r;
        bstate_v_s       = bstate_r;
        rcnt_v_s         = rcnt_r;
        mode_v_s         = mode_r;
        last_v_s         = last_r;
        base_v_s         = base_r;
        fill_ptr_nx_s    = fill_ptr_r;
        new_stream_nx_s  = new_stream_r;
        stream_base_nx_s = stream_base_r;
        if (acc_in_s) begin
            mem_v_s[fill_ptr_r][rcnt_r[fill_ptr_r][KW-1:0]] = in_data;
            rcnt_v_s[fill_ptr_r] = rcnt_r[fill_ptr_r] + RW'(1);
            last_v_s[fill_ptr_r] = in_last;
            new_stream_nx_s      = in_last;
            stream_base_nx_s     = new_stream_r ? addr_start : stream_base_r;
            if (rcnt_r[fill_ptr_r] == RW'(0)) begin
                mode_v_s[fill_ptr_r] = mode;
                base_v_s[fill_ptr_r] = new_stream_r ? addr_start : stream_base_r;
            end else begin
                mode_v_s[fill_ptr_r] = mode_r[fill_ptr_r];
            end
            if (rcnt_r[fill_ptr_r] == LAST_ROW || in_last) begin
                bstate_v_s[fill_ptr_r] = B_FULL;
                fill_ptr_nx_s          = ~fill_ptr_r;
            end else begin
                bstate_v_s[fill_ptr_r] = B_FILLING;
            end
        end else begin
            new_stream_nx_s = new_stream_r;
        end

        dstate_nx_s    = dstate_r;
        drain_ptr_nx_s = drain_ptr_r;
        k_nx_s         = k_r;
        offset_nx_s    = offset_r;
        off_s          = offset_r;
        out_we_nx_s    = out_we_r;
        out_addr_nx_s  = out_addr_r;
        done_nx_s      = 1'b0;
        blocks_nx_s    = blocks_r;
        start_s        = 1'b0;
        start_bank_s   = drain_ptr_r;
        start_off_s    = offset_r;
        sel_bank_s     = drain_ptr_r;
        sel_k_s        = KW'(0);
        load_word_s    = 1'b0;
        drain_len_s    = mode_r[drain_ptr_r] ? rcnt_r[drain_ptr_r] : ROWS;
        case (dstate_r)
            D_IDLE: begin
                if (bstate_v_s[drain_ptr_r] == B_FULL) begin
                    start_s = 1'b1;
                end else begin
                    out_we_nx_s = 1'b0;
                end
            end
            D_DRAIN: begin
                if (out_acc_s) begin
                    if (k_r == drain_len_s - RW'(1)) begin
                        bstate_v_s[drain_ptr_r] = B_EMPTY;
                        rcnt_v_s[drain_ptr_r]   = RW'(0);
                        last_v_s[drain_ptr_r]   = 1'b0;
                        blocks_nx_s             = blocks_r + CWIDTH'(1);
                        drain_ptr_nx_s          = ~drain_ptr_r;
                        if (last_r[drain_ptr_r]) begin
                            done_nx_s = 1'b1;
                            off_s     = AWIDTH'(0);
                        end else begin
                            off_s     = offset_r + AWIDTH'(1);
                        end
                        offset_nx_s = off_s;
                        // The other bank may be completing its fill in this very cycle
                        if (bstate_v_s[~drain_ptr_r] == B_FULL) begin
                            start_s      = 1'b1;
                            start_bank_s = ~drain_ptr_r;
                            start_off_s  = off_s;
                        end else begin
                            out_we_nx_s = 1'b0;
                            dstate_nx_s = D_IDLE;
                        end
                    end else begin
                        k_nx_s        = k_r + RW'(1);
                        offset_nx_s   = offset_r + AWIDTH'(1);
                        out_addr_nx_s = out_addr_r + AWIDTH'(1);
                        sel_k_s       = KW'(k_r + RW'(1));
                        load_word_s   = 1'b1;
                    end
                end else begin
                    out_we_nx_s = out_we_r;
                end
            end
            default: begin
                dstate_nx_s = D_IDLE;
                out_we_nx_s = 1'b0;
            end
        endcase

        if (start_s) begin
            bstate_v_s[start_bank_s] = B_DRAINING;
            dstate_nx_s   = D_DRAIN;
            k_nx_s        = RW'(0);
            out_we_nx_s   = 1'b1;
            sel_bank_s    = start_bank_s;
            sel_k_s       = KW'(0);
            load_word_s   = 1'b1;
            out_addr_nx_s = base_v_s[start_bank_s] + start_off_s;
        end else begin
            sel_bank_s = drain_ptr_r;
        end

        word_s = {DWIDTH{1'b0}};
        if (mode_v_s[sel_bank_s]) begin
            word_s = mem_v_s[sel_bank_s][sel_k_s];
        end else begin
            for (int i = 0; i < DWIDTH; i++) begin
                word_s[i] = (RW'(i) < rcnt_v_s[sel_bank_s]) ? mem_v_s[sel_bank_s][i][sel_k_s] : 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                bstate_r[b] <= B_EMPTY;
                rcnt_r[b]   <= RW'(0);
                mode_r[b]   <= 1'b0;
                last_r[b]   <= 1'b0;
                base_r[b]   <= AWIDTH'(0);
            end
            fill_ptr_r    <= 1'b0;
            drain_ptr_r   <= 1'b0;
            new_stream_r  <= 1'b1;
            stream_base_r <= AWIDTH'(0);
            offset_r      <= AWIDTH'(0);
            dstate_r      <= D_IDLE;
            k_r           <= RW'(0);
            out_we_r      <= 1'b0;
            out_data_r    <= {DWIDTH{1'b0}};
            out_addr_r    <= AWIDTH'(0);
            done_r        <= 1'b0;
            blocks_r      <= CWIDTH'(0);
        end else begin
            mem_r         <= mem_v_s;
            bstate_r      <= bstate_v_s;
            rcnt_r        <= rcnt_v_s;
            mode_r        <= mode_v_s;
            last_r        <= last_v_s;
            base_r        <= base_v_s;
            fill_ptr_r    <= fill_ptr_nx_s;
            drain_ptr_r   <= drain_ptr_nx_s;
            new_stream_r  <= new_stream_nx_s;
            stream_base_r <= stream_base_nx_s;
            offset_r      <= offset_nx_s;
            dstate_r      <= dstate_nx_s;
            k_r           <= k_nx_s;
            out_we_r      <= out_we_nx_s;
            out_data_r    <= load_word_s ? word_s : out_data_r;
            out_addr_r    <= out_addr_nx_s;
            done_r        <= done_nx_s;
            blocks_r      <= blocks_nx_s;
        end
    end

    assign out_we         = out_we_r;
    assign out_data       = out_data_r;
    assign out_addr       = out_addr_r;
    assign done           = done_r;
    assign blocks_written = blocks_r;

endmodule

// File: tb/tb_swizzle_cram_to_dram_pp.sv
// Directed bench for swizzle_cram_to_dram_pp with 4x4 blocks and an 8-bit address.
module tb_swizzle_cram_to_dram_pp;
    localparam int DW = 4;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [AW-1:0] addr_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_we;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_ready;
    logic          done;
    logic [CW-1:0] blocks_written;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_we = -1;
    int stalls = 0;
    int last_acc = 0;
    logic [DW-1:0] wd_q[$];
    logic [AW-1:0] wa_q[$];
    int            done_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;

    swizzle_cram_to_dram_pp #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .addr_start(addr_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_we(out_we), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
        .done(done), .blocks_written(blocks_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write collector and hold-while-stalled check, sampled mid-cycle
    always @(negedge clk) begin
        if (out_we && out_ready) begin
            wd_q.push_back(out_data);
            wa_q.push_back(out_addr);
        end
        if (out_we && first_we < 0) first_we = cyc;
        if (done) done_q.push_back(cyc);
        if (prev_stall && out_we) begin
            checks++;
            assert (out_data === prev_d && out_addr === prev_a) else begin
                errors++;
                $error("FAIL stall_hold: observed %0h@%0h expected %0h@%0h", out_data, out_addr, prev_d, prev_a);
            end
        end
        prev_stall = out_we && !out_ready;
        prev_d = out_data;
        prev_a = out_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear();
        wd_q.delete();
        wa_q.delete();
        done_q.delete();
        first_we = -1;
    endtask

    task automatic send(input logic [DW-1:0] w, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n > 0) stalls++;
        last_acc = cyc;
        step();
    endtask

    task automatic stop_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wd_q.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [DW-1:0] ed [12], input logic [AW-1:0] a0);
        check({tag, "_count"}, wd_q.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ea;
            ea = a0 + AW'(i);
            check($sformatf("%s_data%0d", tag, i), (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hxxxxxxxx, 32'(ed[i]));
            check($sformatf("%s_addr%0d", tag, i), (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hxxxxxxxx, 32'(ea));
        end
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp_d [12];
        int t4;
        reset = 1'b1; mode = 1'b0; addr_start = 8'h10;
        in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_we", out_we, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_done", done, 0);
        check("rst_blocks", blocks_written, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        step();

        // Basic transpose: single full row of ones turns into bit 0 of every word
        clear();
        send(4'hF, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b1);
        t4 = last_acc;
        stop_in();
        wait_writes(4); idle(4);
        exp_d = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_writes("t1", 4, exp_d, 8'h10);
        check("t1_latency", first_we, t4 + 1);
        check("t1_done_count", done_q.size(), 1);
        check("t1_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, t4 + 5);
        check("t1_blocks", blocks_written, 1);

        // Identity and reversed identity back to back through both banks
        clear();
        stalls = 0;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h8, 1'b0);
        t4 = last_acc;
        send(4'h8, 1'b0); send(4'h4, 1'b0); send(4'h2, 1'b0); send(4'h1, 1'b1);
        stop_in();
        wait_writes(8); idle(4);
        exp_d = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        check_writes("t2", 8, exp_d, 8'h10);
        check("t2_in_stalls", stalls, 0);
        check("t2_latency", first_we, t4 + 1);
        check("t2_done_count", done_q.size(), 1);
        check("t2_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, t4 + 9);
        check("t2_blocks", blocks_written, 3);

        // Partial block, transpose pads with zero rows
        clear();
        addr_start = 8'h20;
        send(4'h3, 1'b0); send(4'h1, 1'b1);
        stop_in();
        wait_writes(4); idle(4);
        exp_d = '{4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_writes("t3t", 4, exp_d, 8'h20);
        check("t3t_blocks", blocks_written, 4);

        // Partial block, pass-through writes only the rows received
        clear();
        mode = 1'b1; addr_start = 8'h30;
        send(4'h3, 1'b0); send(4'h1, 1'b1);
        stop_in();
        mode = 1'b0;
        wait_writes(2); idle(6);
        exp_d = '{4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_writes("t3p", 2, exp_d, 8'h30);
        check("t3p_done_count", done_q.size(), 1);
        check("t3p_blocks", blocks_written, 5);

        // Backpressure: both banks fill, input stalls, output holds word 0
        clear();
        addr_start = 8'h40; out_ready = 1'b0;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h8, 1'b0);
        send(4'hF, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0);
        stop_in();
        @(negedge clk);
        check("t4_in_ready_full", in_ready, 0);
        check("t4_stall_we", out_we, 1);
        check("t4_stall_data", out_data, 4'h1);
        check("t4_stall_addr", out_addr, 8'h40);
        idle(2);
        @(negedge clk);
        check("t4_in_ready_still", in_ready, 0);
        check("t4_hold_data", out_data, 4'h1);
        check("t4_hold_addr", out_addr, 8'h40);
        step();
        out_ready = 1'b1;
        send(4'h8, 1'b0); send(4'h4, 1'b0); send(4'h2, 1'b0); send(4'h1, 1'b1);
        stop_in();
        wait_writes(12); idle(4);
        exp_d = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
        check_writes("t4", 12, exp_d, 8'h40);
        check("t4_done_count", done_q.size(), 1);
        check("t4_blocks", blocks_written, 8);

        // Address wrap past the top of the address space
        clear();
        addr_start = 8'hFE;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h8, 1'b1);
        stop_in();
        wait_writes(4); idle(4);
        exp_d = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_writes("t5", 4, exp_d, 8'hFE);
        check("t5_blocks", blocks_written, 9);

        // Reset while word 2 is on the bus
        clear();
        addr_start = 8'h50;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h8, 1'b1);
        stop_in();
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_word2", out_data, 4'h4);
        step();
        @(negedge clk);
        check("t6_rst_we", out_we, 0);
        check("t6_rst_blocks", blocks_written, 0);
        check("t6_rst_in_ready", in_ready, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rel_in_ready", in_ready, 1);
        idle(10);
        check("t6_write_count", wd_q.size(), 3);
        check("t6_done_count", done_q.size(), 0);
        check("t6_idle_we", out_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
